// File: rtl/instr_aligner_pkg.sv
// Shared constants and decode-stage types for the RV32IMC fetch aligner.
package instr_aligner_pkg;

  localparam logic [1:0]  INSN_LEN32_CODE = 2'b11;
  localparam logic [31:0] HALFWORD_BYTES  = 32'd2;
  localparam logic [31:0] WORD_BYTES      = 32'd4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] instrPc;
    logic        isCompressed;
  } aligned_instr_t;

  // Length is encoded in the low two bits of the first halfword.
  function automatic logic is_len32(input logic [15:0] hw);
    return hw[1:0] == INSN_LEN32_CODE;
  endfunction

endpackage

// File: rtl/instr_aligner_if.sv
// Fetch-response, redirect and decode-side signals of the instruction aligner.
interface instr_aligner_if;

  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchAddr;
  logic [31:0] fetchData;
  logic        flush;
  logic [31:0] flushPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] instrPc;
  logic        isCompressed;

  // Environment side: fetch unit, redirect logic and decoder.
  modport master (
    output fetchValid, fetchAddr, fetchData, flush, flushPc, instrReady,
    input  fetchReady, instrValid, instruction, instrPc, isCompressed
  );

  modport slave (
    input  fetchValid, fetchAddr, fetchData, flush, flushPc, instrReady,
    output fetchReady, instrValid, instruction, instrPc, isCompressed
  );

endinterface

// File: rtl/instr_aligner.sv
// Turns word-aligned fetch words into whole 16/32-bit instructions with PCs,
// handling halfword-aligned starts, straddling instructions and redirects.
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  instr_aligner_if.slave bus
);

  logic [63:0] buf_reg, buf_next;
  logic [2:0]  count_reg, count_next;
  logic [31:0] head_pc_reg, head_pc_next;
  logic [31:0] exp_addr_reg, exp_addr_next;
  logic        drop_low_reg, drop_low_next;

  logic [15:0]    head_hw;
  logic           head_is32;
  logic           instr_avail;
  aligned_instr_t out_instr;

  assign head_hw     = buf_reg[15:0];
  assign head_is32   = is_len32(head_hw);
  assign instr_avail = head_is32 ? (count_reg >= 3'd2) : (count_reg >= 3'd1);

  // Outputs depend on registered state only; flush merely masks valid.
  always_comb begin
    out_instr         = '0;
    out_instr.instrPc = head_pc_reg;
    if (instr_avail) begin
      out_instr.instruction  = head_is32 ? buf_reg[31:0] : {16'h0000, head_hw};
      out_instr.isCompressed = !head_is32;
    end
  end

  assign bus.instrValid   = instr_avail && !bus.flush;
  assign bus.instruction  = out_instr.instruction;
  assign bus.instrPc      = out_instr.instrPc;
  assign bus.isCompressed = out_instr.isCompressed;
  assign bus.fetchReady   = (count_reg <= 3'd2);

  logic        consume;
  logic [2:0]  shift_hw;
  logic [63:0] buf_shifted;
  logic [2:0]  count_shifted;
  logic        word_match;
  logic [2:0]  append_cnt;
  logic [15:0] app_hw0, app_hw1;
  logic [63:0] buf_merged;

  assign consume       = bus.instrValid && bus.instrReady;
  assign shift_hw      = consume ? (head_is32 ? 3'd2 : 3'd1) : 3'd0;
  assign buf_shifted   = !consume ? buf_reg :
                         head_is32 ? {32'h0, buf_reg[63:32]} : {16'h0, buf_reg[63:16]};
  assign count_shifted = count_reg - shift_hw;

  assign word_match = bus.fetchValid && bus.fetchReady && (bus.fetchAddr == exp_addr_reg);
  assign append_cnt = word_match ? (drop_low_reg ? 3'd1 : 3'd2) : 3'd0;
  assign app_hw0    = drop_low_reg ? bus.fetchData[31:16] : bus.fetchData[15:0];
  assign app_hw1    = bus.fetchData[31:16];

  // Each slot keeps its shifted halfword or takes an appended one; since
  // fetchReady caps count at 2, shifted count plus append never exceeds 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    localparam logic [2:0] SLOT = 3'(gi);
    logic [2:0] rel;
    assign rel = SLOT - count_shifted;
    assign buf_merged[gi*16 +: 16] =
        (SLOT < count_shifted)  ? buf_shifted[gi*16 +: 16] :
        (rel < append_cnt)      ? ((rel == 3'd0) ? app_hw0 : app_hw1) :
                                  16'h0000;
  end

  always_comb begin
    buf_next      = buf_merged;
    count_next    = count_shifted + append_cnt;
    head_pc_next  = head_pc_reg;
    exp_addr_next = exp_addr_reg;
    drop_low_next = drop_low_reg;
    if (bus.flush) begin
      buf_next      = '0;
      count_next    = 3'd0;
      head_pc_next  = bus.flushPc;
      exp_addr_next = {bus.flushPc[31:2], 2'b00};
      drop_low_next = bus.flushPc[1];
    end else begin
      if (consume) begin
        head_pc_next = head_pc_reg + (head_is32 ? WORD_BYTES : HALFWORD_BYTES);
      end
      if (word_match) begin
        exp_addr_next = exp_addr_reg + WORD_BYTES;
        drop_low_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg      <= '0;
      count_reg    <= 3'd0;
      head_pc_reg  <= BOOT_ADDR;
      exp_addr_reg <= {BOOT_ADDR[31:2], 2'b00};
      drop_low_reg <= BOOT_ADDR[1];
    end else begin
      buf_reg      <= buf_next;
      count_reg    <= count_next;
      head_pc_reg  <= head_pc_next;
      exp_addr_reg <= exp_addr_next;
      drop_low_reg <= drop_low_next;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner: alignment, straddling, flush, backpressure, reset.
module tb_instr_aligner;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_aligner_if bus ();

  instr_aligner #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    bus.fetchValid = 1'b1;
    bus.fetchAddr  = addr;
    bus.fetchData  = data;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ins,
                              input logic [31:0] pc, input logic comp);
    check({tag, "_valid"}, 32'(bus.instrValid), 32'd1);
    check({tag, "_instr"}, bus.instruction, ins);
    check({tag, "_pc"},    bus.instrPc, pc);
    check({tag, "_comp"},  32'(bus.isCompressed), 32'(comp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] drain_ins [6];
  logic        drain_rdy [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.fetchValid = 1'b0; bus.fetchAddr = '0; bus.fetchData = '0;
    bus.flush = 1'b0; bus.flushPc = '0; bus.instrReady = 1'b0;
    drain_ins = '{32'h4511, 32'h4515, 32'h4519, 32'h451D, 32'h4521, 32'h4525};
    drain_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    step(); step();
    check("rst_valid", 32'(bus.instrValid), 32'd0);
    check("rst_fready", 32'(bus.fetchReady), 32'd1);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_comp", 32'(bus.isCompressed), 32'd0);
    check("rst_pc", bus.instrPc, 32'd0);
    rst_n = 1'b1;
    step();

    // Single 32-bit instruction
    fetch(32'h0, 32'h00A0_0093);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t1", 32'h00A0_0093, 32'h0, 1'b0);
    bus.instrReady = 1'b1;
    step();
    check("t1_empty", 32'(bus.instrValid), 32'd0);
    check("t1_pc_next", bus.instrPc, 32'h4);

    // Two compressed instructions in one word
    fetch(32'h4, 32'h4505_4501);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t2a", 32'h0000_4501, 32'h4, 1'b1);
    step();
    expect_instr("t2b", 32'h0000_4505, 32'h6, 1'b1);
    step();
    check("t2_empty", 32'(bus.instrValid), 32'd0);

    // Straddling 32-bit instruction
    fetch(32'h8, 32'h0093_4501);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t3a", 32'h0000_4501, 32'h8, 1'b1);
    step();
    check("t3_wait", 32'(bus.instrValid), 32'd0);
    fetch(32'hC, 32'h0000_00A0);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t3b", 32'h00A0_0093, 32'hA, 1'b0);
    step();
    expect_instr("t3c", 32'h0000_0000, 32'hE, 1'b1);
    step();
    check("t3_empty", 32'(bus.instrValid), 32'd0);

    // Flush to a halfword-aligned PC, stale word discarded
    bus.flush = 1'b1; bus.flushPc = 32'h102;
    #1 check("t4_flush_valid", 32'(bus.instrValid), 32'd0);
    step();
    bus.flush = 1'b0;
    bus.instrReady = 1'b0;
    fetch(32'h008, 32'h0001_0001);
    step();
    bus.fetchValid = 1'b0;
    check("t4_stale", 32'(bus.instrValid), 32'd0);
    fetch(32'h100, 32'h4509_1234);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t4a", 32'h0000_4509, 32'h102, 1'b1);
    bus.instrReady = 1'b1;
    fetch(32'h104, 32'h00A0_0093);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t4b", 32'h00A0_0093, 32'h104, 1'b0);
    step();
    check("t4_empty", 32'(bus.instrValid), 32'd0);
    check("t4_pc", bus.instrPc, 32'h108);

    // Backpressure: decoder stalls while fetch keeps streaming
    bus.instrReady = 1'b0;
    fetch(32'h108, 32'h4515_4511);
    check("t5_fr0", 32'(bus.fetchReady), 32'd1);
    step();
    fetch(32'h10C, 32'h451D_4519);
    check("t5_fr1", 32'(bus.fetchReady), 32'd1);
    expect_instr("t5_h1", 32'h4511, 32'h108, 1'b1);
    step();
    fetch(32'h110, 32'h4525_4521);
    for (int c = 0; c < 3; c++) begin
      check("t5_fr_full", 32'(bus.fetchReady), 32'd0);
      expect_instr("t5_hold", 32'h4511, 32'h108, 1'b1);
      step();
    end
    bus.instrReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.fetchValid = (k <= 2);
      expect_instr("t5_drain", drain_ins[k], 32'h108 + 32'(2 * k), 1'b1);
      check("t5_drain_fr", 32'(bus.fetchReady), 32'(drain_rdy[k]));
      step();
    end
    bus.fetchValid = 1'b0;
    check("t5_empty", 32'(bus.instrValid), 32'd0);
    check("t5_pc", bus.instrPc, 32'h114);

    // Flush colliding with a fetch handshake and an instruction handshake
    bus.instrReady = 1'b0;
    fetch(32'h114, 32'h4531_452D);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t6a", 32'h452D, 32'h114, 1'b1);
    bus.flush = 1'b1; bus.flushPc = 32'h200;
    bus.instrReady = 1'b1;
    fetch(32'h118, 32'hDEAD_BEEF);
    #1 check("t6_flush_valid", 32'(bus.instrValid), 32'd0);
    check("t6_flush_fr", 32'(bus.fetchReady), 32'd1);
    step();
    bus.flush = 1'b0; bus.fetchValid = 1'b0; bus.instrReady = 1'b0;
    check("t6_post_valid", 32'(bus.instrValid), 32'd0);
    check("t6_post_pc", bus.instrPc, 32'h200);
    check("t6_post_instr", bus.instruction, 32'd0);
    check("t6_post_fr", 32'(bus.fetchReady), 32'd1);
    fetch(32'h118, 32'h0001_0001);
    step();
    bus.fetchValid = 1'b0;
    check("t6_stale", 32'(bus.instrValid), 32'd0);
    fetch(32'h200, 32'h0000_0001);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t6b", 32'h0000_0001, 32'h200, 1'b1);
    bus.instrReady = 1'b1;
    step();
    expect_instr("t6c", 32'h0000_0000, 32'h202, 1'b1);
    step();
    check("t6_empty", 32'(bus.instrValid), 32'd0);

    // Asynchronous reset in the middle of operation
    bus.instrReady = 1'b0;
    fetch(32'h204, 32'h4505_4501);
    step();
    bus.fetchValid = 1'b0;
    expect_instr("t7", 32'h4501, 32'h204, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(bus.instrValid), 32'd0);
    check("t7_rst_pc", bus.instrPc, 32'h0);
    check("t7_rst_fr", 32'(bus.fetchReady), 32'd1);
    check("t7_rst_comp", 32'(bus.isCompressed), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
# instr_aligner

Instruction fetch aligner for the RV32IMC core. It sits between the instruction-memory response port and the decoder stage. It accepts word-aligned 32-bit fetch words and emits one whole instruction per handshake, either a 16-bit compressed or a 32-bit instruction, together with its PC. Halfword alignment, instructions that straddle two words, and redirect handling are resolved here, so the decoder always receives one complete instruction.

## Interface
- `BOOT_ADDR`, default `32'h0000_0000`: PC of the first instruction after reset. Must be halfword-aligned.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetchValid` in 1: a fetch word is presented.
- `fetchReady` out 1: the aligner accepts the fetch word this cycle.
- `fetchAddr` in 32: word-aligned byte address of `fetchData`.
- `fetchData` in 32: fetch word, little-endian (halfword 0 in `[15:0]`).
- `flush` in 1: redirect request from branch/jump/trap logic.
- `flushPc` in 32: new PC, halfword-aligned; sampled when `flush` is high.
- `instrValid` out 1: an instruction is presented to the decoder.
- `instrReady` in 1: the decoder accepts the instruction.
- `instruction` out 32: the raw instruction. A compressed instruction is zero-extended to `{16'b0, hw}`.
- `instrPc` out 32: the PC of `instruction`.
- `isCompressed` out 1: high when `instruction[1:0] != 2'b11`.

## Operation
- Internal state:
  - 64-bit halfword buffer `buf` (4 halfwords, head at `[15:0]`).
  - `count` in 0..4 (valid halfwords).
  - `headPc`.
  - `expAddr`: the next expected word address.
  - `dropLow`: discard halfword 0 of the next accepted word.
- Reset values:
  - `count=0`, `headPc=BOOT_ADDR`, `expAddr={BOOT_ADDR[31:2],2'b00}`, `dropLow=BOOT_ADDR[1]`.
  - Outputs: `instrValid=0`, `fetchReady=1`, `instruction=0`, `isCompressed=0`, `instrPc=BOOT_ADDR`.
- Fetch acceptance:
  - `fetchReady = (count <= 2)`, driven from registered state only.
  - A fetch handshake is `fetchValid && fetchReady`.
- Stale word drop: an accepted word with `fetchAddr != expAddr` is discarded without changing the buffer, `expAddr` or `dropLow`.
- Matching word:
  - Append 2 halfwords to the buffer. If `dropLow` is set, append only `fetchData[31:16]` and clear `dropLow`.
  - `expAddr += 4`.
- Instruction length is taken from the head halfword `[1:0]`:
  - `2'b11` means 32 bits. Valid requires `count>=2`; `instruction = buf[31:0]`.
  - Any other value means 16 bits. Valid requires `count>=1`; `instruction = {16'b0, buf[15:0]}`.
- Output handshake (`instrValid && instrReady`):
  - Shift the buffer down by 1 or 2 halfwords.
  - `count` decreases by the same amount.
  - `headPc` increases by 2 or 4.
- Consume and append in the same cycle:
  - The shift is applied first, then new halfwords are appended at the new `count`.
  - `count` ends at or below 4 in all cases.
- Flush (highest priority):
  - `count=0`, `headPc=flushPc`, `expAddr={flushPc[31:2],2'b00}`, `dropLow=flushPc[1]`.
  - Any word accepted in the flush cycle is dropped.
  - `instrValid` is forced to 0 while `flush=1`.
- No instruction legality checking; illegal encodings, including `16'h0000`, pass through unchanged. Address wrap at `32'hFFFF_FFFC` is modulo 2^32.

## Timing
- `instrValid`, `instruction`, `instrPc` and `isCompressed` are combinational from registered state only. There is no path from `instrReady` or `fetchValid`.
- Latency:
  - A word accepted in cycle N makes its first instruction valid in cycle N+1.
  - A straddling 32-bit instruction becomes valid in the cycle after its second word is accepted.
- Output stability: while `instrValid=1 && instrReady=0`, the outputs hold stable until the handshake or a flush.
- Throughput: one instruction per cycle, provided fetch supplies one word per cycle.
- Reset mid-operation: an asserted `rst_n=0` immediately clears the buffer and forces the reset values, regardless of handshakes in flight.

## Structure
- Add to `loopyV_data_types`:
  - `INSN_LEN32_CODE = 2'b11`.
  - `HALFWORD_BYTES = 2`, `WORD_BYTES = 4`.
  - A packed struct `AlignedInstrType {instruction, instrPc, isCompressed}` for the decode-stage interface.
- Single module, no sub-modules. Expansion of compressed instructions to 32-bit form is done downstream in a separate `compressed_expander` block, not in this block.

## Test plan
- Reset with `BOOT_ADDR=0`; feed word `0x00A00093` at addr 0 -> next cycle `instrValid=1`, `instruction=0x00A00093`, `instrPc=0`, `isCompressed=0`.
- Feed word `0x4505_4501` at addr 0 -> two instructions in consecutive cycles: `0x00004501` at PC 0, then `0x00004505` at PC 2, both with `isCompressed=1`.
- Straddle: word `0x0093_4501` at 0, then word `0x0000_00A0` at 4 -> `0x4501` at PC 0, then `0x00A00093` at PC 2, valid only after the second word is accepted.
- Flush with `flushPc=0x102`, then words at 0x100 and 0x104 -> halfword 0 of the 0x100 word is dropped; first output has `instrPc=0x102`. A stale word at 0x008 presented after the flush is accepted and discarded.
- Backpressure: hold `instrReady=0` for 5 cycles while feeding 16-bit instructions -> `fetchReady` drops once `count>2`, outputs stay stable, and no halfword is lost or duplicated.
- Assert `flush` in the same cycle as both a fetch handshake and `instrReady=1` -> the word is dropped, `instrValid=0`, and state equals the post-flush reset values.
